// File: rtl/pipe_execute_stage_if.sv
// Decode/hazard-side view of the PIPE execute stage: E-register inputs, exception
// inputs that gate CC writes, and everything the stage forwards toward M.
interface pipe_execute_stage_if #(
  parameter int WIDTH = 64
);
  logic             e_stall;
  logic             e_bubble;
  logic [3:0]       d_icode;
  logic [3:0]       d_ifun;
  logic [WIDTH-1:0] d_valC;
  logic [WIDTH-1:0] d_valA;
  logic [WIDTH-1:0] d_valB;
  logic [3:0]       d_dstE;
  logic [3:0]       d_dstM;
  logic             m_exc;
  logic             w_exc;
  logic [3:0]       e_icode;
  logic [WIDTH-1:0] e_valA;
  logic [WIDTH-1:0] e_valE;
  logic [3:0]       e_dstE;
  logic [3:0]       e_dstM;
  logic             e_Cnd;
  logic             e_busy;
  logic [2:0]       cc_out;

  modport master (
    output e_stall, e_bubble, d_icode, d_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM,
           m_exc, w_exc,
    input  e_icode, e_valA, e_valE, e_dstE, e_dstM, e_Cnd, e_busy, cc_out
  );

  modport slave (
    input  e_stall, e_bubble, d_icode, d_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM,
           m_exc, w_exc,
    output e_icode, e_valA, e_valE, e_dstE, e_dstM, e_Cnd, e_busy, cc_out
  );
endinterface

// File: rtl/pipe_execute_stage.sv
// Y86-64 PIPE execute stage: E pipeline register, ALU, condition codes, Cnd,
// and an iterative shift-add multiplier for OPq ifun 4.
module pipe_execute_stage #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input logic             clk_i,
  input logic             rst_ni,
  pipe_execute_stage_if.slave ex
);
  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;
  localparam logic [3:0] F_MUL = 4'h4;

  localparam logic [WIDTH-1:0] PLUS8    = WIDTH'(8);
  localparam logic [WIDTH-1:0] MINUS8   = ~WIDTH'(7);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  typedef struct packed {
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] valC;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [3:0]       dstE;
    logic [3:0]       dstM;
  } e_reg_t;

  localparam e_reg_t E_NOP = '{icode: I_NOP, ifun: 4'h0, valC: '0, valA: '0, valB: '0,
                               dstE: R_NONE, dstM: R_NONE};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_e;

  e_reg_t           er_q, er_d;
  mul_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2:0]       cc_q, cc_d;

  logic             is_mul, busy, e_load, cc_block;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r, sum, diff, acc_step;
  logic [3:0]       alufun;
  logic             alu_of, cnd;

  assign is_mul   = MUL_EN && (er_q.icode == I_OPQ) && (er_q.ifun == F_MUL);
  assign busy     = is_mul && (state_q == S_IDLE || state_q == S_RUN);
  assign e_load   = !busy && !ex.e_stall;
  assign cc_block = ex.m_exc || ex.w_exc;
  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    alu_a = '0;
    case (er_q.icode)
      I_RRMOVQ, I_OPQ:                       alu_a = er_q.valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_IADDQ: alu_a = er_q.valC;
      I_CALL, I_PUSHQ:                       alu_a = MINUS8;
      I_RET, I_POPQ:                         alu_a = PLUS8;
      default:                               alu_a = '0;
    endcase
    alu_b = '0;
    case (er_q.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ, I_IADDQ: alu_b = er_q.valB;
      default: alu_b = '0;
    endcase
    alufun = (er_q.icode == I_OPQ) ? er_q.ifun : F_ADD;
    sum    = alu_b + alu_a;
    diff   = alu_b - alu_a;
    alu_r  = sum;
    alu_of = (alu_a[MSB] == alu_b[MSB]) && (sum[MSB] != alu_a[MSB]);
    case (alufun)
      F_SUB: begin
        alu_r  = diff;
        alu_of = (alu_a[MSB] != alu_b[MSB]) && (diff[MSB] != alu_b[MSB]);
      end
      F_AND: begin alu_r = alu_a & alu_b; alu_of = 1'b0; end
      F_XOR: begin alu_r = alu_a ^ alu_b; alu_of = 1'b0; end
      // Without the multiplier, ifun 4 keeps its legacy XOR meaning.
      F_MUL: begin alu_r = MUL_EN ? acc_q : (alu_a ^ alu_b); alu_of = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    cnd = 1'b0;
    case (er_q.ifun)
      4'h0: cnd = 1'b1;
      4'h1: cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'h2: cnd = cc_q[1] ^ cc_q[0];
      4'h3: cnd = cc_q[2];
      4'h4: cnd = !cc_q[2];
      4'h5: cnd = !(cc_q[1] ^ cc_q[0]);
      4'h6: cnd = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
      default: cnd = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      S_IDLE: if (is_mul) begin
        state_d  = S_RUN;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = er_q.valA;
        mplier_d = er_q.valB;
      end
      S_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: if (e_load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Multiply sets CC once, from the final partial sum, on its RUN->DONE edge.
  always_comb begin
    cc_d = cc_q;
    if (!cc_block) begin
      if (state_q == S_RUN && cnt_q == CNT_LAST)
        cc_d = {acc_step == '0, acc_step[MSB], 1'b0};
      else if (er_q.icode == I_OPQ && !is_mul)
        cc_d = {alu_r == '0, alu_r[MSB], alu_of};
    end
  end

  always_comb begin
    er_d = er_q;
    if (e_load) begin
      if (ex.e_bubble) er_d = E_NOP;
      else er_d = '{icode: ex.d_icode, ifun: ex.d_ifun, valC: ex.d_valC, valA: ex.d_valA,
                    valB: ex.d_valB, dstE: ex.d_dstE, dstM: ex.d_dstM};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      er_q     <= E_NOP;
      cc_q     <= 3'b100;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      er_q     <= er_d;
      cc_q     <= cc_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign ex.e_icode = er_q.icode;
  assign ex.e_valA  = er_q.valA;
  assign ex.e_valE  = alu_r;
  assign ex.e_dstE  = (er_q.icode == I_RRMOVQ && !cnd) ? R_NONE : er_q.dstE;
  assign ex.e_dstM  = er_q.dstM;
  assign ex.e_Cnd   = cnd;
  assign ex.e_busy  = busy;
  assign ex.cc_out  = cc_q;
endmodule
